// File: rtl/conv_sa_ctrl_pkg.sv
// Shared constants for the systolic-array convolution controller: array shape,
// FSM state encoding and skew-line bit layout.
package conv_sa_ctrl_pkg;

    localparam int CONV_M  = 32;
    localparam int CONV_P  = 16;
    localparam int CONV_NB = CONV_M / 8;

    localparam int STATE_W = 3;
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RST    = 3'd1;
    localparam logic [2:0] S_STREAM = 3'd2;
    localparam logic [2:0] S_FLUSH  = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;
    localparam logic [2:0] S_POST   = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    // Bit positions of the row-0 events carried down the skew line.
    localparam int SKEW_W   = 2;
    localparam int SK_RST   = 0;
    localparam int SK_FLUSH = 1;

    // A single block still needs a 1-bit select port.
    function automatic int sel_width(input int nb);
        return (nb > 1) ? $clog2(nb) : 1;
    endfunction

endpackage

// File: rtl/conv_sa_ctrl_skew.sv
// Parameterised shift register; tap i holds the input delayed i+1 cycles.
module conv_sa_ctrl_skew #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH-1:0]             din,
    output logic [DEPTH-1:0][WIDTH-1:0]  taps
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            taps <= '0;
        end else begin
            taps[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                taps[i] <= taps[i-1];
            end
        end
    end

endmodule

// File: rtl/conv_sa_ctrl.sv
// Sequencer for an M-row systolic array: streams rounds of vectors, skews the
// row reset/flush flags, tracks per-block psum write pointers and runs post-processing.
module conv_sa_ctrl
    import conv_sa_ctrl_pkg::*;
#(
    parameter int M = CONV_M,
    parameter int P = CONV_P
) (
    input  logic                        clk,
    input  logic                        rst,
    // Job handshake: a job is accepted on any cycle with start_vld && start_rdy;
    // start_rdy depends only on state, never on start_vld.
    input  logic                        start_vld,
    output logic                        start_rdy,
    input  logic [15:0]                 n_vec,
    input  logic [7:0]                  n_rnd,
    output logic                        x_rd_en,
    output logic [M-1:0]                mat_rst,
    output logic [M-1:0]                mat_flush,
    output logic [M/8-1:0]              mat_psum_vld,
    output logic [M/8-1:0]              mat_psum_last_rnd,
    output logic [M/8*3-1:0]            mat_psum_wr_addr,
    output logic [M/8*3-1:0]            mat_psum_prefetch_addr,
    output logic                        post_rstp,
    output logic [sel_width(M/8)-1:0]   post_sel,
    output logic                        busy,
    output logic                        done,
    output logic [STATE_W-1:0]          dbg_state
);

    localparam int NB    = M / 8;
    localparam int SEL_W = sel_width(NB);

    logic [STATE_W-1:0]          state;
    logic [15:0]                 phase_cnt;
    logic [7:0]                  rnd_cnt;
    logic [15:0]                 n_vec_q;
    logic [7:0]                  n_rnd_q;
    logic                        accept;
    logic [M-1:0][SKEW_W-1:0]    sk_taps;
    logic [NB-1:0][7:0]          blk_rnd;

    assign accept    = start_vld && (state == S_IDLE);
    assign start_rdy = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign x_rd_en   = (state == S_STREAM);
    assign post_rstp = (state == S_POST) && (phase_cnt == 16'd0);
    assign done      = (state == S_DONE);

    // phase_cnt is shared: vectors in STREAM, drain cycles in DRAIN, steps in POST.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            phase_cnt <= '0;
            rnd_cnt   <= '0;
            n_vec_q   <= '0;
            n_rnd_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_vld) begin
                        state     <= S_RST;
                        phase_cnt <= '0;
                        rnd_cnt   <= '0;
                        n_vec_q   <= (n_vec == 16'd0) ? 16'd1 : n_vec;
                        n_rnd_q   <= (n_rnd == 8'd0) ? 8'd1 : n_rnd;
                    end
                end
                S_RST: begin
                    state     <= S_STREAM;
                    phase_cnt <= '0;
                end
                S_STREAM: begin
                    if (phase_cnt == n_vec_q - 16'd1) begin
                        state     <= S_FLUSH;
                        phase_cnt <= '0;
                    end else begin
                        phase_cnt <= phase_cnt + 16'd1;
                    end
                end
                S_FLUSH: begin
                    if (rnd_cnt == n_rnd_q - 8'd1) begin
                        state     <= S_DRAIN;
                        phase_cnt <= '0;
                    end else begin
                        state   <= S_RST;
                        rnd_cnt <= rnd_cnt + 8'd1;
                    end
                end
                S_DRAIN: begin
                    if (phase_cnt == 16'(M + 7)) begin
                        state     <= S_POST;
                        phase_cnt <= '0;
                    end else begin
                        phase_cnt <= phase_cnt + 16'd1;
                    end
                end
                S_POST: begin
                    if (phase_cnt == 16'(NB)) begin
                        state     <= S_DONE;
                        phase_cnt <= '0;
                    end else begin
                        phase_cnt <= phase_cnt + 16'd1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        post_sel = '0;
        if ((state == S_POST) && (phase_cnt != 16'd0)) begin
            post_sel = SEL_W'(phase_cnt - 16'd1);
        end
    end

    conv_sa_ctrl_skew #(
        .DEPTH(M),
        .WIDTH(SKEW_W)
    ) u_skew (
        .clk  (clk),
        .rst  (rst),
        .din  ({(state == S_FLUSH), (state == S_RST)}),
        .taps (sk_taps)
    );

    for (genvar r = 0; r < M; r++) begin : g_row
        assign mat_rst[r]   = sk_taps[r][SK_RST];
        assign mat_flush[r] = sk_taps[r][SK_FLUSH];
    end

    // Block b's psum is complete when the flush leaves its last row (8b+7).
    // Each block counts its own pulses; the low 3 bits are the write pointer.
    for (genvar b = 0; b < NB; b++) begin : g_blk
        assign mat_psum_vld[b]              = sk_taps[8*b+7][SK_FLUSH];
        assign mat_psum_last_rnd[b]         = mat_psum_vld[b] && (blk_rnd[b] == n_rnd_q - 8'd1);
        assign mat_psum_wr_addr[3*b +: 3]       = blk_rnd[b][2:0];
        assign mat_psum_prefetch_addr[3*b +: 3] = blk_rnd[b][2:0] + 3'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_rnd <= '0;
        end else if (accept) begin
            blk_rnd <= '0;
        end else begin
            for (int b = 0; b < NB; b++) begin
                if (mat_psum_vld[b]) begin
                    blk_rnd[b] <= blk_rnd[b] + 8'd1;
                end
            end
        end
    end

    // The debug tap is only meaningful for a real array with columns.
    if (P > 0) begin : g_dbg
        assign dbg_state = state;
    end else begin : g_no_dbg
        assign dbg_state = '0;
    end

endmodule
